pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width (32 registers, all writable, no hardwired zero).
REQ-002 SHALL have parameter STALL_CNT_W, default 16, width of the stall counter.
REQ-003 SHALL have ports clk input 1, single clock, all logic on the rising edge.
REQ-004 SHALL have port reset input 1; reset is synchronous and active-low.
REQ-005 SHALL have ports instr_valid input 1 and instr input 32, IF-stage instruction offer; instr_ready output 1, ID accepts this cycle.
REQ-006 SHALL have ports id_en output 1 (ID latch load), ex_en output 1 (EX latch load), ex_bubble output 1 and wb_bubble output 1 (inject NOP).
REQ-007 SHALL have ports fwd_a and fwd_b output 2 each, operand source for the instruction in ID: 00 regfile, 01 EX result, 10 WB result.
REQ-008 SHALL have ports mem_req output 1 and mem_ack input 1, data-memory handshake for LOAD.
REQ-009 SHALL have ports rf_we output 1 and rf_waddr output REG_AW, the WB regfile write port.
REQ-010 SHALL have ports illegal_op output 1, a one-cycle pulse, and stall_cnt output STALL_CNT_W.

Function
REQ-011 SHALL decode fields opcode[31:26], rd[25:21], rs1[20:16], rs2[15:11]; ADD=000000 and SUB=000001 read rs1 and rs2; LOAD=000010 reads rs1 (base) only; all three write rd.
REQ-012 SHALL treat any other opcode as a NOP (no reads, no write) and pulse illegal_op in the cycle it is accepted into ID.
REQ-013 SHALL keep a shadow pipeline of ID, EX and WB slots holding {valid, rd, rs1, rs2, uses_rs2, is_load, writes}.
REQ-014 SHALL assert load_use when the ID instruction reads a register equal to ex_rd while EX holds a valid LOAD.
REQ-015 On load_use, SHALL hold ID (id_en=0, instr_ready=0) and set ex_bubble=1 for that cycle.
REQ-016 SHALL select fwd per operand with priority EX (valid, writes, not LOAD, rd match) > WB (valid, writes, rd match) > regfile.
REQ-017 SHALL drive mem_req=1 combinationally whenever EX holds a valid LOAD.
REQ-018 SHALL have FSM states RUN and MEM_WAIT: RUN->MEM_WAIT on mem_req && !mem_ack; MEM_WAIT->RUN on mem_ack.
REQ-019 Freeze (mem_req && !mem_ack) SHALL hold ID and EX (id_en=ex_en=0, instr_ready=0) and set wb_bubble=1.
REQ-020 Freeze SHALL take precedence over load_use, and load_use SHALL still be evaluated in the mem_ack cycle.
REQ-021 SHALL drive rf_we = wb_valid && wb_writes and rf_waddr = wb_rd.
REQ-022 With no hazard, SHALL set instr_ready=1, id_en=instr_valid, ex_en=1, and give one instruction per cycle throughput.
REQ-023 With instr_valid=0 and ID accepting, the ID slot SHALL become invalid (bubble).

Reset
REQ-024 reset=0 at an edge SHALL clear all slot valids and stall_cnt and force RUN, including mid MEM_WAIT.
REQ-025 In the cycle after reset SHALL drive mem_req=0, rf_we=0, illegal_op=0, fwd_a=fwd_b=00 and instr_ready=1.

Configuration
REQ-026 With HAZ_PERF_EN defined, stall_cnt SHALL increment each cycle instr_ready=0 (freeze or load_use), saturating at all-ones.
REQ-027 Without HAZ_PERF_EN, stall_cnt SHALL be tied to 0 and no counter SHALL be synthesised.

Structure
REQ-028 Package pipe_pkg SHALL hold the opcode constants, the fwd encoding constants and the FSM state enum.
REQ-029 Sub-module pipe_fwd_sel (one operand: compare, priority, LOAD-block flag) SHALL be instantiated twice.

Verification
REQ-030 ADD R1,R2,R3 then SUB R4,R1,R5 back-to-back -> SUB in ID: fwd_a=01, fwd_b=00, no stall.
REQ-031 LOAD R6,100(R7), mem_ack same cycle, then ADD R8,R6,R4 -> instr_ready=0 for 1 cycle, ex_bubble=1; next cycle fwd_a=10.
REQ-032 LOAD with mem_ack 3 cycles late -> mem_req high 4 cycles, MEM_WAIT 3 cycles, wb_bubble=1 for 3 cycles, rf_we=0 during those cycles.
REQ-033 Instruction 0xFC000000 -> illegal_op=1 for one cycle, rf_we=0 when it reaches WB.
REQ-034 reset=0 during MEM_WAIT -> next cycle mem_req=0, rf_we=0, FSM RUN.
REQ-035 HAZ_PERF_EN: REQ-032 LOAD followed by a dependent ADD -> stall_cnt=4; preload near all-ones -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard controller: opcodes, forwarding
// source encodings and the data-memory wait FSM states.
package pipe_pkg;

  localparam int unsigned OPC_W = 6;
  localparam int unsigned FWD_W = 2;

  localparam logic [OPC_W-1:0] OPC_ADD  = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 6'b000001;
  localparam logic [OPC_W-1:0] OPC_LOAD = 6'b000010;

  localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Operand source selection for one source register of the ID instruction.
// Also flags a read of a register that a LOAD in EX has not yet produced.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              rs_used_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic              ex_valid_i,
  input  logic              ex_writes_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              wb_valid_i,
  input  logic              wb_writes_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic [FWD_W-1:0]  fwd_o,
  output logic              load_hit_o
);

  logic ex_match;
  logic wb_match;

  // EX result wins over WB; a LOAD in EX cannot forward and raises load_hit
  always_comb begin
    ex_match   = rs_used_i && ex_valid_i && ex_writes_i && (ex_rd_i == rs_i);
    wb_match   = rs_used_i && wb_valid_i && wb_writes_i && (wb_rd_i == rs_i);
    load_hit_o = ex_match && ex_is_load_i;
    fwd_o      = FWD_RF;
    if (ex_match && !ex_is_load_i) begin
      fwd_o = FWD_EX;
    end else if (wb_match) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 4-stage IF/ID/EX/WB pipeline: tracks ID/EX/WB in a
// shadow pipeline, forwards operands, stalls on load-use and freezes on a
// slow data-memory acknowledge. illegal_op is registered: it pulses in the
// first cycle an unknown opcode sits in ID.
// Optional: define HAZ_PERF_EN to build a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  output logic                   instr_ready,
  output logic                   id_en,
  output logic                   ex_en,
  output logic                   ex_bubble,
  output logic                   wb_bubble,
  output logic [FWD_W-1:0]       fwd_a,
  output logic [FWD_W-1:0]       fwd_b,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_waddr,
  output logic                   illegal_op,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              is_load;
    logic              writes;
  } slot_t;

  slot_t  id_q, ex_q, wb_q;
  slot_t  dec;
  logic   dec_illegal;
  logic   illegal_q;
  state_e state_q;
  logic   freeze;
  logic   load_use;
  logic   ld_hit_a, ld_hit_b;
  logic   unused_bits;

  assign unused_bits = ^{instr[10:0], ex_q.rs1, ex_q.rs2, ex_q.uses_rs1, ex_q.uses_rs2,
                         wb_q.rs1, wb_q.rs2, wb_q.uses_rs1, wb_q.uses_rs2, wb_q.is_load};

  // Decode the offered instruction into a shadow slot
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    dec.valid   = 1'b1;
    dec.rd      = REG_AW'(instr[25:21]);
    dec.rs1     = REG_AW'(instr[20:16]);
    dec.rs2     = REG_AW'(instr[15:11]);
    case (instr[31:26])
      OPC_ADD, OPC_SUB: begin
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        dec.writes   = 1'b1;
      end
      OPC_LOAD: begin
        dec.uses_rs1 = 1'b1;
        dec.is_load  = 1'b1;
        dec.writes   = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_used_i    (id_q.valid && id_q.uses_rs1),
    .rs_i         (id_q.rs1),
    .ex_valid_i   (ex_q.valid),
    .ex_writes_i  (ex_q.writes),
    .ex_is_load_i (ex_q.is_load),
    .ex_rd_i      (ex_q.rd),
    .wb_valid_i   (wb_q.valid),
    .wb_writes_i  (wb_q.writes),
    .wb_rd_i      (wb_q.rd),
    .fwd_o        (fwd_a),
    .load_hit_o   (ld_hit_a)
  );

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_used_i    (id_q.valid && id_q.uses_rs2),
    .rs_i         (id_q.rs2),
    .ex_valid_i   (ex_q.valid),
    .ex_writes_i  (ex_q.writes),
    .ex_is_load_i (ex_q.is_load),
    .ex_rd_i      (ex_q.rd),
    .wb_valid_i   (wb_q.valid),
    .wb_writes_i  (wb_q.writes),
    .wb_rd_i      (wb_q.rd),
    .fwd_o        (fwd_b),
    .load_hit_o   (ld_hit_b)
  );

  assign mem_req    = ex_q.valid && ex_q.is_load;
  assign freeze     = mem_req && !mem_ack;
  assign load_use   = ld_hit_a || ld_hit_b;
  assign rf_we      = wb_q.valid && wb_q.writes;
  assign rf_waddr   = wb_q.rd;
  assign illegal_op = illegal_q;

  // Stage enables: a memory freeze outranks a load-use stall
  always_comb begin
    instr_ready = 1'b1;
    id_en       = instr_valid;
    ex_en       = 1'b1;
    ex_bubble   = 1'b0;
    wb_bubble   = 1'b0;
    if (freeze) begin
      instr_ready = 1'b0;
      id_en       = 1'b0;
      ex_en       = 1'b0;
      wb_bubble   = 1'b1;
    end else if (load_use) begin
      instr_ready = 1'b0;
      id_en       = 1'b0;
      ex_bubble   = 1'b1;
    end
  end

  // Advance the shadow pipeline and the illegal-opcode pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      id_q      <= '0;
      ex_q      <= '0;
      wb_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (instr_ready) id_q <= instr_valid ? dec : '0;
      if (ex_en) ex_q <= ex_bubble ? '0 : id_q;
      wb_q      <= wb_bubble ? '0 : ex_q;
      illegal_q <= instr_ready && instr_valid && dec_illegal;
    end
  end

  // Data-memory wait FSM: tracks cycles spent waiting on mem_ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:      if (freeze) state_q <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (mem_ack) state_q <= ST_RUN;
        default:     state_q <= ST_RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which ID refused an instruction
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!instr_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
